// File: rtl/axi_slv_mem.sv
`timescale 1ns/1ps
// axi_slv_mem : AXI slave memory responder.
//
// Accepts one write burst at a time on AW/W, stores it in an internal
// byte-enabled RAM and answers on B. Serves one read burst at a time on AR/R
// from the same RAM. The read and write engines are independent and run
// concurrently.
//
// Ports
//   aclk, aresetn        clock (posedge) and synchronous active-low reset
//   aw*                  write address channel (id, addr, len, size, burst)
//   w*                   write data channel (id, data, strobes, last)
//   b*                   write response channel (id, resp)
//   ar*                  read address channel (id, addr, len, size, burst)
//   r*                   read data channel (id, data, resp, last)
//
// Error beats (reserved burst, oversize beat, out-of-range address) never
// touch the RAM. A WRAP length error, an id mismatch or a misplaced wlast
// flags SLVERR but still writes. Bursts always run len+1 beats.
module axi_slv_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [3:0]              awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [3:0]              wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [3:0]              bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [3:0]              arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [3:0]              rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [2:0]            MAX_SIZE = 3'(OFF);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Beats of these bursts must never reach the RAM.
  function automatic logic hard_err(input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'b11) || (size > MAX_SIZE);
  endfunction

  function automatic logic wrap_len_err(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'b10) &&
           !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
  endfunction

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> OFF) >= DEPTH_A;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[OFF +: IDX_W];
  endfunction

  // Address of the following beat. WRAP uses a power-of-two window, so the
  // modulo reduces to a mask.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0]            len,
                                                      input logic [2:0]            size,
                                                      input logic [1:0]            burst);
    logic [ADDR_WIDTH-1:0] nbytes, aligned, wbytes, bound, res;
    nbytes  = ONE_A << size;
    aligned = addr & ~(nbytes - ONE_A);
    wbytes  = (ADDR_WIDTH'(len) + ONE_A) << size;
    bound   = addr & ~(wbytes - ONE_A);
    case (burst)
      2'b01:   res = aligned + nbytes;
      2'b10:   res = bound + ((aligned + nbytes - bound) & (wbytes - ONE_A));
      default: res = addr;
    endcase
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------------------------------------------------------- write
  w_state_e              w_state_q, w_state_d;
  logic [3:0]            w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic                  w_err_q, w_err_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [3:0]            bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  w_hard, w_beat_err, mem_we;
  logic [IDX_W-1:0]      mem_widx;

  always_comb begin
    w_state_d  = w_state_q;
    w_id_d     = w_id_q;
    w_addr_d   = w_addr_q;
    w_len_d    = w_len_q;
    w_size_d   = w_size_q;
    w_burst_d  = w_burst_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    w_hard     = 1'b0;
    w_beat_err = 1'b0;
    mem_we     = 1'b0;
    mem_widx   = word_idx(w_addr_q);
    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          w_id_d    = awid;
          w_addr_d  = awaddr;
          w_len_d   = awlen;
          w_size_d  = awsize;
          w_burst_d = awburst;
          w_cnt_d   = 8'd0;
          w_err_d   = wrap_len_err(awburst, awlen);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          w_hard     = hard_err(w_burst_q, w_size_q) || out_of_range(w_addr_q);
          w_beat_err = w_hard || (wid != w_id_q) || (wlast != (w_cnt_q == w_len_q));
          // A beat landing on the reset edge is abandoned with the burst.
          mem_we     = aresetn && !w_hard;
          w_err_d    = w_err_q || w_beat_err;
          w_addr_d   = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
          w_cnt_d    = w_cnt_q + 8'd1;
          if (w_cnt_q == w_len_q) begin
            w_state_d = W_RESP;
            bid_d     = w_id_q;
            bresp_d   = (w_err_q || w_beat_err) ? 2'b10 : 2'b00;
          end
        end
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Burst context is always reloaded on the address handshake.
  always_ff @(posedge aclk) begin
    w_id_q    <= w_id_d;
    w_addr_q  <= w_addr_d;
    w_len_q   <= w_len_d;
    w_size_q  <= w_size_d;
    w_burst_q <= w_burst_d;
    w_cnt_q   <= w_cnt_d;
    w_err_q   <= w_err_d;
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[mem_widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, ld_addr;
  logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic                  r_hdr_q, r_hdr_d, ld, ld_hdr, rd_err;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [3:0]            rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    r_hdr_d   = r_hdr_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    ld        = 1'b0;
    ld_addr   = r_addr_q;
    ld_hdr    = r_hdr_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          r_addr_d  = araddr;
          r_len_d   = arlen;
          r_size_d  = arsize;
          r_burst_d = arburst;
          r_cnt_d   = 8'd0;
          r_hdr_d   = hard_err(arburst, arsize) || wrap_len_err(arburst, arlen);
          rid_d     = arid;
          rlast_d   = (arlen == 8'd0);
          ld        = 1'b1;
          ld_addr   = araddr;
          ld_hdr    = r_hdr_d;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
            rlast_d   = 1'b0;
          end else begin
            r_addr_d = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
            r_cnt_d  = r_cnt_q + 8'd1;
            rlast_d  = (r_cnt_d == r_len_q);
            ld       = 1'b1;
            ld_addr  = r_addr_d;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // The RAM is sampled at the edge, so a same-cycle write is not seen.
    rd_err = ld_hdr || out_of_range(ld_addr);
    if (ld) begin
      rdata_d = rd_err ? '0 : mem[word_idx(ld_addr)];
      rresp_d = rd_err ? 2'b10 : 2'b00;
    end
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_ff @(posedge aclk) begin
    r_addr_q  <= r_addr_d;
    r_len_q   <= r_len_d;
    r_size_q  <= r_size_d;
    r_burst_q <= r_burst_d;
    r_cnt_q   <= r_cnt_d;
    r_hdr_q   <= r_hdr_d;
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_slv_mem.sv
`timescale 1ns/1ps
// Directed bench for axi_slv_mem: inputs change and outputs are sampled on
// the falling clock edge.
module tb_axi_slv_mem;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  awid, wid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int tests  = 0;
  int failed = 0;

  logic [31:0] wr_data [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];

  logic [3:0] g_bid, g_rid;
  logic [1:0] g_bresp;
  logic       g_prompt, g_bafter, g_rafter, g_tmo;
  int         g_bbad, g_nb, g_sbad;

  always #5 aclk = ~aclk;

  axi_slv_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (awready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) g_tmo = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [3:0] id, input logic [31:0] d, input logic [3:0] strb,
                           input logic last);
    int n = 0;
    wid = id; wdata = d; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (wready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) g_tmo = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [3:0] wid_v, input logic [3:0] strb, input int bdelay);
    int n = 0;
    g_tmo = 1'b0;
    send_aw(id, addr, len, size, burst);
    for (int b = 0; b <= int'(len); b++) send_beat(wid_v, wr_data[b], strb, b == int'(len));
    g_prompt = bvalid;
    while (bvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) g_tmo = 1'b1;
    g_bid = bid; g_bresp = bresp; g_bbad = 0;
    for (int i = 0; i < bdelay; i++) begin
      @(negedge aclk);
      if (bvalid !== 1'b1 || bid !== g_bid || bresp !== g_bresp) g_bbad++;
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    g_bafter = bvalid;
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic toggle);
    int n = 0;
    logic        have = 1'b0;
    logic [31:0] h_d;
    logic [1:0]  h_r;
    logic        h_l;
    g_tmo = 1'b0; g_nb = 0; g_sbad = 0; g_rid = 4'hx;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (arready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) g_tmo = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    n = 0;
    while (g_nb <= int'(len) && n < 100) begin
      rready = toggle ? (n % 2 == 1) : 1'b1;
      if (rvalid === 1'b1) begin
        if (have && (rdata !== h_d || rresp !== h_r || rlast !== h_l)) g_sbad++;
        if (g_nb == 0) g_rid = rid;
        if (rready) begin
          rd_data[g_nb] = rdata; rd_resp[g_nb] = rresp; rd_last[g_nb] = rlast;
          g_nb++; have = 1'b0;
        end else begin
          h_d = rdata; h_r = rresp; h_l = rlast; have = 1'b1;
        end
      end
      @(negedge aclk);
      n++;
    end
    if (n >= 100) g_tmo = 1'b1;
    rready = 1'b0;
    g_rafter = rvalid;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    tests++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
      failed++;
      $display("FAIL reset_ctrl got=%b exp=000000", {awready, wready, bvalid, arready, rvalid, rlast});
    end
    tests++;
    if (bid !== 4'h0 || bresp !== 2'b0 || rid !== 4'h0 || rdata !== 32'h0 || rresp !== 2'b0) begin
      failed++;
      $display("FAIL reset_data got bid=%h bresp=%h rid=%h rdata=%h rresp=%h exp all 0",
               bid, bresp, rid, rdata, rresp);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    tests++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      failed++;
      $display("FAIL reset_release got awready=%b arready=%b exp 1 1", awready, arready);
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hA0 + i;
    write_burst(4'h5, 32'h10, 8'd3, 3'd2, 2'b01, 4'h5, 4'hF, 0);
    tests++;
    if (g_tmo || g_prompt !== 1'b1) begin
      failed++;
      $display("FAIL incr_b_latency got bvalid=%b tmo=%b exp bvalid=1 tmo=0", g_prompt, g_tmo);
    end
    tests++;
    if (g_bid !== 4'h5 || g_bresp !== 2'b00) begin
      failed++;
      $display("FAIL incr_b got bid=%h bresp=%b exp 5 00", g_bid, g_bresp);
    end
    read_burst(4'h3, 32'h10, 8'd3, 3'd2, 2'b01, 1'b0);
    tests++;
    if (g_tmo || g_nb != 4 || g_rid !== 4'h3 || g_rafter !== 1'b0) begin
      failed++;
      $display("FAIL incr_r_ctrl got beats=%0d rid=%h tmo=%b rvalid_after=%b exp 4 3 0 0",
               g_nb, g_rid, g_tmo, g_rafter);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rd_data[i] !== 32'hA0 + i || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
        failed++;
        $display("FAIL incr_r_beat%0d got data=%h resp=%b last=%b exp data=%h resp=00 last=%b",
                 i, rd_data[i], rd_resp[i], rd_last[i], 32'hA0 + i, i == 3);
      end
    end
  endtask

  task automatic test_strobe();
    wr_data[0] = 32'h11223344;
    write_burst(4'h1, 32'h40, 8'd0, 3'd2, 2'b01, 4'h1, 4'hF, 0);
    wr_data[0] = 32'hFFFFFFFF;
    write_burst(4'h1, 32'h40, 8'd0, 3'd2, 2'b01, 4'h1, 4'b0101, 0);
    read_burst(4'h1, 32'h40, 8'd0, 3'd2, 2'b01, 1'b0);
    tests++;
    if (g_tmo || g_nb != 1 || rd_data[0] !== 32'h11FF33FF || rd_resp[0] !== 2'b00) begin
      failed++;
      $display("FAIL strobe got data=%h resp=%b beats=%0d exp 11ff33ff 00 1",
               rd_data[0], rd_resp[0], g_nb);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hB0 + i;
    write_burst(4'h2, 32'h38, 8'd3, 3'd2, 2'b10, 4'h2, 4'hF, 0);
    tests++;
    if (g_tmo || g_bresp !== 2'b00) begin
      failed++;
      $display("FAIL wrap_b got bresp=%b tmo=%b exp 00 0", g_bresp, g_tmo);
    end
    // Words 0x30..0x3C linearly: 0x30=B2 0x34=B3 0x38=B0 0x3C=B1
    read_burst(4'h2, 32'h30, 8'd3, 3'd2, 2'b01, 1'b0);
    tests++;
    if (g_tmo || rd_data[0] !== 32'hB2 || rd_data[1] !== 32'hB3 ||
        rd_data[2] !== 32'hB0 || rd_data[3] !== 32'hB1) begin
      failed++;
      $display("FAIL wrap_layout got %h %h %h %h exp b2 b3 b0 b1",
               rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
    end
    read_burst(4'h2, 32'h38, 8'd3, 3'd2, 2'b10, 1'b0);
    tests++;
    if (g_tmo || rd_data[0] !== 32'hB0 || rd_data[1] !== 32'hB1 ||
        rd_data[2] !== 32'hB2 || rd_data[3] !== 32'hB3 || rd_last[3] !== 1'b1) begin
      failed++;
      $display("FAIL wrap_read got %h %h %h %h last=%b exp b0 b1 b2 b3 1",
               rd_data[0], rd_data[1], rd_data[2], rd_data[3], rd_last[3]);
    end
  endtask

  task automatic test_errors();
    wr_data[0] = 32'h12121212;
    write_burst(4'h4, 32'h1000, 8'd0, 3'd2, 2'b01, 4'h4, 4'hF, 0);
    tests++;
    if (g_tmo || g_bresp !== 2'b10) begin
      failed++;
      $display("FAIL err_oor_write got bresp=%b exp 10", g_bresp);
    end
    read_burst(4'h4, 32'h1000, 8'd0, 3'd2, 2'b01, 1'b0);
    tests++;
    if (g_tmo || rd_resp[0] !== 2'b10 || rd_data[0] !== 32'h0 || rd_last[0] !== 1'b1) begin
      failed++;
      $display("FAIL err_oor_read got resp=%b data=%h last=%b exp 10 0 1",
               rd_resp[0], rd_data[0], rd_last[0]);
    end
    wr_data[0] = 32'hDEAD0000; wr_data[1] = 32'hDEAD0001;
    write_burst(4'h6, 32'h10, 8'd1, 3'd2, 2'b11, 4'h6, 4'hF, 0);
    tests++;
    if (g_tmo || g_bresp !== 2'b10) begin
      failed++;
      $display("FAIL err_burst11 got bresp=%b exp 10", g_bresp);
    end
    wr_data[0] = 32'hBAD0BAD0;
    write_burst(4'h6, 32'h10, 8'd0, 3'd3, 2'b01, 4'h6, 4'hF, 0);
    tests++;
    if (g_tmo || g_bresp !== 2'b10) begin
      failed++;
      $display("FAIL err_oversize got bresp=%b exp 10", g_bresp);
    end
    read_burst(4'h6, 32'h10, 8'd1, 3'd2, 2'b01, 1'b0);
    tests++;
    if (g_tmo || rd_data[0] !== 32'hA0 || rd_data[1] !== 32'hA1 || rd_resp[1] !== 2'b00) begin
      failed++;
      $display("FAIL err_ram_untouched got %h %h resp=%b exp a0 a1 00",
               rd_data[0], rd_data[1], rd_resp[1]);
    end
    wr_data[0] = 32'hCAFEF00D;
    write_burst(4'h7, 32'hFFC, 8'd0, 3'd2, 2'b01, 4'h7, 4'hF, 0);
    read_burst(4'h7, 32'hFFC, 8'd1, 3'd2, 2'b01, 1'b0);
    tests++;
    if (g_tmo || rd_data[0] !== 32'hCAFEF00D || rd_resp[0] !== 2'b00 ||
        rd_data[1] !== 32'h0 || rd_resp[1] !== 2'b10 || rd_last[1] !== 1'b1) begin
      failed++;
      $display("FAIL err_top_edge got %h/%b %h/%b exp cafef00d/00 0/10",
               rd_data[0], rd_resp[0], rd_data[1], rd_resp[1]);
    end
    wr_data[0] = 32'h5555AAAA;
    write_burst(4'h2, 32'h80, 8'd0, 3'd2, 2'b01, 4'h3, 4'hF, 0);
    tests++;
    if (g_tmo || g_bresp !== 2'b10 || g_bid !== 4'h2) begin
      failed++;
      $display("FAIL err_wid got bresp=%b bid=%h exp 10 2", g_bresp, g_bid);
    end
    read_burst(4'h2, 32'h80, 8'd0, 3'd2, 2'b01, 1'b0);
    tests++;
    if (g_tmo || rd_data[0] !== 32'h5555AAAA || rd_resp[0] !== 2'b00) begin
      failed++;
      $display("FAIL err_wid_written got %h/%b exp 5555aaaa/00", rd_data[0], rd_resp[0]);
    end
  endtask

  task automatic test_backpressure();
    wr_data[0] = 32'h12345678;
    write_burst(4'h7, 32'h90, 8'd0, 3'd2, 2'b01, 4'h7, 4'hF, 5);
    tests++;
    if (g_tmo || g_bbad != 0 || g_bid !== 4'h7 || g_bresp !== 2'b00 || g_bafter !== 1'b0) begin
      failed++;
      $display("FAIL bp_b got unstable=%0d bid=%h bresp=%b bvalid_after=%b exp 0 7 00 0",
               g_bbad, g_bid, g_bresp, g_bafter);
    end
    read_burst(4'h9, 32'h10, 8'd3, 3'd2, 2'b01, 1'b1);
    tests++;
    if (g_tmo || g_nb != 4 || g_sbad != 0 || g_rafter !== 1'b0) begin
      failed++;
      $display("FAIL bp_r_ctrl got beats=%0d unstable=%0d rvalid_after=%b exp 4 0 0",
               g_nb, g_sbad, g_rafter);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rd_data[i] !== 32'hA0 + i || rd_last[i] !== (i == 3)) begin
        failed++;
        $display("FAIL bp_r_beat%0d got %h last=%b exp %h last=%b",
                 i, rd_data[i], rd_last[i], 32'hA0 + i, i == 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    int late_b = 0;
    g_tmo = 1'b0;
    send_aw(4'hC, 32'hA0, 8'd3, 3'd2, 2'b01);
    send_beat(4'hC, 32'hC0, 4'hF, 1'b0);
    send_beat(4'hC, 32'hC1, 4'hF, 1'b0);
    wid = 4'hC; wdata = 32'hC2; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    aresetn = 1'b0;
    @(negedge aclk);
    tests++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      failed++;
      $display("FAIL midrst_cleared got=%b exp=00000", {awready, wready, bvalid, arready, rvalid});
    end
    aresetn = 1'b1; wvalid = 1'b0;
    @(negedge aclk);
    tests++;
    if (g_tmo || awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin
      failed++;
      $display("FAIL midrst_idle got awready=%b wready=%b bvalid=%b exp 1 0 0",
               awready, wready, bvalid);
    end
    repeat (5) begin
      @(negedge aclk);
      if (bvalid !== 1'b0) late_b++;
    end
    tests++;
    if (late_b != 0) begin
      failed++;
      $display("FAIL midrst_no_b got bvalid cycles=%0d exp 0", late_b);
    end
    read_burst(4'h1, 32'hA0, 8'd1, 3'd2, 2'b01, 1'b0);
    tests++;
    if (g_tmo || rd_data[0] !== 32'hC0 || rd_data[1] !== 32'hC1) begin
      failed++;
      $display("FAIL midrst_kept got %h %h exp c0 c1", rd_data[0], rd_data[1]);
    end
    read_burst(4'h1, 32'h40, 8'd0, 3'd2, 2'b01, 1'b0);
    tests++;
    if (g_tmo || rd_data[0] !== 32'h11FF33FF) begin
      failed++;
      $display("FAIL midrst_old_data got %h exp 11ff33ff", rd_data[0]);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    @(negedge aclk);
    test_reset();
    test_incr();
    test_strobe();
    test_wrap();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
